// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception arbiter: exception codes, flag bit positions, CP0 addresses.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exc_ctrl_pkg;

  // Exception codes driven to cp0_reg (0 = no exception)
  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;
  localparam logic [31:0] EXC_ADDR = 32'h0000_000f;

  // Bit positions inside exc_flags_i
  localparam int FLAG_FETCH = 0;
  localparam int FLAG_RI    = 1;
  localparam int FLAG_SYS   = 2;
  localparam int FLAG_TR    = 3;
  localparam int FLAG_OV    = 4;
  localparam int FLAG_ERET  = 5;
  localparam int FLAG_LS    = 6;

  // CP0 register addresses
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } exc_state_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// Bundle of memory-stage, CP0 and redirect signals around the exception arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; stall_i is carried as a plain input.
interface exc_ctrl_if;

  logic [31:0] inst_addr_i;
  logic        in_delay_slot_i;
  logic [6:0]  exc_flags_i;
  logic [31:0] mem_addr_i;
  logic        stall_i;
  logic [5:0]  int_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;

  logic [31:0] excepttype_o;
  logic [31:0] bad_address_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delay_slot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  // Pipeline / CP0 side
  modport master (
    output inst_addr_i, in_delay_slot_i, exc_flags_i, mem_addr_i, stall_i, int_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, bad_address_o, current_inst_addr_o, is_in_delay_slot_o,
    input  flush_o, new_pc_o, busy_o
  );

  // Exception arbiter side
  modport slave (
    input  inst_addr_i, in_delay_slot_i, exc_flags_i, mem_addr_i, stall_i, int_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, bad_address_o, current_inst_addr_o, is_in_delay_slot_o,
    output flush_o, new_pc_o, busy_o
  );

endinterface

// File: rtl/exc_ctrl_cp0_fwd.sv
// Forwards an in-flight MTC0 write onto the status/cause/epc values seen by the arbiter.
// Latency: combinational.
// Backpressure: none.
module exc_ctrl_cp0_fwd
  import exc_ctrl_pkg::*;
(
  input  logic [31:0] i_status,
  input  logic [31:0] i_cause,
  input  logic [31:0] i_epc,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_waddr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_status,
  output logic [31:0] o_cause,
  output logic [31:0] o_epc
);

  // Status and epc take the whole word; cause only exposes its software-writable IP[1:0] and IV/WP bits
  always_comb begin
    o_status = i_status;
    o_cause  = i_cause;
    o_epc    = i_epc;
    if (i_wb_we) begin
      case (i_wb_waddr)
        CP0_REG_STATUS: o_status = i_wb_data;
        CP0_REG_EPC:    o_epc    = i_wb_data;
        CP0_REG_CAUSE: begin
          o_cause[9:8]   = i_wb_data[9:8];
          o_cause[23:22] = i_wb_data[23:22];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception arbiter: picks one exception per cycle, drives cp0_reg, flush and redirect PC.
// Latency: exception/flush/new_pc combinational in the flag cycle; busy_o registered, DRAIN_CYCLES long.
// Backpressure: no issue while stall_i, on a bubble, or during the post-flush drain window.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          DRAIN_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  exc_ctrl_if.slave    bus
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  exc_state_t  r_state;
  logic [3:0]  r_drain_cnt;
  logic [5:0]  r_pend_ip;
  logic        r_busy;

  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_epc;
  logic [7:0]  w_ip_masked;
  logic        w_int_req;
  logic        w_slot;
  logic        w_int_issue;
  logic        w_issue;
  logic [31:0] w_code;
  logic [31:0] w_bad;
  logic        w_unused;

  exc_ctrl_cp0_fwd u_cp0_fwd (
    .i_status   (bus.cp0_status_i),
    .i_cause    (bus.cp0_cause_i),
    .i_epc      (bus.cp0_epc_i),
    .i_wb_we    (bus.wb_cp0_we_i),
    .i_wb_waddr (bus.wb_cp0_waddr_i),
    .i_wb_data  (bus.wb_cp0_data_i),
    .o_status   (w_status),
    .o_cause    (w_cause),
    .o_epc      (w_epc)
  );

  // Only IE, EXL, IM and the software IP bits participate in arbitration
  assign w_unused = ^{w_status[31:16], w_status[7:2], w_cause[31:10], w_cause[7:0]};

  // Hardware IP lines sit above the two software IP bits, matching status.IM[7:0]
  assign w_ip_masked = {r_pend_ip, w_cause[9:8]} & w_status[15:8];
  assign w_int_req   = w_status[0] & ~w_status[1] & (w_ip_masked != 8'd0);

  // Reset is folded in so every output reads zero while rst is held
  assign w_slot      = ~rst & (r_state == ST_IDLE) & ~bus.stall_i & (bus.inst_addr_i != 32'd0);
  assign w_int_issue = w_slot & w_int_req;

  // Fixed-priority selection of the single exception reported this cycle
  always_comb begin
    w_code = EXC_NONE;
    w_bad  = 32'd0;
    if (w_slot) begin
      if (w_int_req) begin
        w_code = EXC_INT;
      end else if (bus.exc_flags_i[FLAG_FETCH]) begin
        w_code = EXC_ADDR;
        w_bad  = bus.inst_addr_i;
      end else if (bus.exc_flags_i[FLAG_RI]) begin
        w_code = EXC_RI;
      end else if (bus.exc_flags_i[FLAG_SYS]) begin
        w_code = EXC_SYS;
      end else if (bus.exc_flags_i[FLAG_TR]) begin
        w_code = EXC_TR;
      end else if (bus.exc_flags_i[FLAG_OV]) begin
        w_code = EXC_OV;
      end else if (bus.exc_flags_i[FLAG_LS]) begin
        w_code = EXC_ADDR;
        w_bad  = bus.mem_addr_i;
      end else if (bus.exc_flags_i[FLAG_ERET]) begin
        w_code = EXC_ERET;
      end
    end
  end

  assign w_issue = (w_code != EXC_NONE);

  assign bus.excepttype_o        = w_code;
  assign bus.bad_address_o       = w_bad;
  assign bus.current_inst_addr_o = bus.inst_addr_i;
  assign bus.is_in_delay_slot_o  = bus.in_delay_slot_i;
  assign bus.flush_o             = w_issue;
  assign bus.new_pc_o            = !w_issue ? 32'd0 : (w_code == EXC_ERET) ? w_epc : EXC_VECTOR;
  assign bus.busy_o              = r_busy;

  // Sticky interrupt latch: cleared by an interrupt issue, new lines still OR in on that edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_ip <= 6'd0;
    end else begin
      r_pend_ip <= (w_int_issue ? 6'd0 : r_pend_ip) | bus.int_i;
    end
  end

  // Drain FSM: after any flush, hold off new issues for DRAIN_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= 4'd0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_INIT;
            r_busy      <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 4'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: priority, forwarding, interrupt latching, drain window, reset.
// Latency: inputs applied 1ns after posedge, outputs checked 1ns later.
// Backpressure: stall_i exercised directly.
module tb_exc_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  exc_ctrl_if bus ();

  exc_ctrl #(
    .EXC_VECTOR   (32'h8000_0180),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next edge and return per-cycle inputs to a bubble
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.inst_addr_i     = 32'd0;
    bus.in_delay_slot_i = 1'b0;
    bus.exc_flags_i     = 7'd0;
    bus.mem_addr_i      = 32'd0;
    bus.stall_i         = 1'b0;
    bus.int_i           = 6'd0;
    bus.wb_cp0_we_i     = 1'b0;
    bus.wb_cp0_waddr_i  = 5'd0;
    bus.wb_cp0_data_i   = 32'd0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_exc(input string tag, input logic [31:0] code, input logic [31:0] bad,
                            input logic [31:0] pc);
    check({tag, ".code"}, bus.excepttype_o, code);
    check({tag, ".bad"}, bus.bad_address_o, bad);
    check({tag, ".flush"}, {31'd0, bus.flush_o}, {31'd0, code != 32'd0});
    check({tag, ".pc"}, bus.new_pc_o, pc);
  endtask

  initial begin
    rst = 1'b1;
    bus.cp0_status_i = 32'd0;
    bus.cp0_cause_i  = 32'd0;
    bus.cp0_epc_i    = 32'd0;
    cyc();
    // Held in reset with a valid syscall present: nothing may issue
    bus.inst_addr_i = 32'h0040_0010;
    bus.exc_flags_i = 7'h04;
    settle();
    expect_exc("rst", 32'h0, 32'h0, 32'h0);
    check("rst.busy", {31'd0, bus.busy_o}, 32'd0);
    cyc();
    rst = 1'b0;

    // Syscall, then exactly two busy cycles
    cyc();
    bus.inst_addr_i     = 32'h0040_0010;
    bus.exc_flags_i     = 7'h04;
    bus.in_delay_slot_i = 1'b1;
    settle();
    expect_exc("sys", 32'h08, 32'h0, 32'h8000_0180);
    check("sys.cur_pc", bus.current_inst_addr_o, 32'h0040_0010);
    check("sys.ds", {31'd0, bus.is_in_delay_slot_o}, 32'd1);
    check("sys.busy0", {31'd0, bus.busy_o}, 32'd0);
    cyc(); settle(); check("sys.busy1", {31'd0, bus.busy_o}, 32'd1);
    cyc(); settle(); check("sys.busy2", {31'd0, bus.busy_o}, 32'd1);
    cyc(); settle(); check("sys.busy3", {31'd0, bus.busy_o}, 32'd0);

    // ERET with epc forwarded from WB
    bus.cp0_epc_i      = 32'h100;
    bus.inst_addr_i    = 32'h0040_0020;
    bus.exc_flags_i    = 7'h20;
    bus.wb_cp0_we_i    = 1'b1;
    bus.wb_cp0_waddr_i = 5'd14;
    bus.wb_cp0_data_i  = 32'h200;
    settle();
    expect_exc("eret", 32'h0e, 32'h0, 32'h200);
    cyc(); cyc(); cyc();

    // Invalid instruction outranks syscall; trap alone
    bus.inst_addr_i = 32'h0040_0030;
    bus.exc_flags_i = 7'h06;
    settle();
    expect_exc("ri", 32'h0a, 32'h0, 32'h8000_0180);
    cyc(); cyc(); cyc();
    bus.inst_addr_i = 32'h0040_0034;
    bus.exc_flags_i = 7'h08;
    settle();
    expect_exc("trap", 32'h0d, 32'h0, 32'h8000_0180);
    cyc(); cyc(); cyc();

    // Interrupt pulse during a bubble, picked up three cycles later
    bus.cp0_status_i = 32'h0000_0401;
    bus.int_i        = 6'h01;
    settle();
    expect_exc("int.bubble", 32'h0, 32'h0, 32'h0);
    cyc(); cyc(); cyc();
    bus.inst_addr_i = 32'h0040_0040;
    settle();
    expect_exc("int", 32'h01, 32'h0, 32'h8000_0180);
    cyc(); cyc(); cyc();
    bus.inst_addr_i = 32'h0040_0044;
    settle();
    expect_exc("int.cleared", 32'h0, 32'h0, 32'h0);

    // WB clears IE in the interrupt cycle: suppressed, then taken once forwarding ends
    bus.int_i = 6'h01;
    cyc();
    bus.inst_addr_i    = 32'h0040_0048;
    bus.wb_cp0_we_i    = 1'b1;
    bus.wb_cp0_waddr_i = 5'd12;
    bus.wb_cp0_data_i  = 32'h0;
    settle();
    expect_exc("int.wb_ie", 32'h0, 32'h0, 32'h0);
    cyc();
    bus.inst_addr_i = 32'h0040_004c;
    settle();
    expect_exc("int.held", 32'h01, 32'h0, 32'h8000_0180);
    cyc(); cyc(); cyc();

    // Software interrupt via forwarded cause: masked bits only
    bus.cp0_status_i   = 32'h0000_0101;
    bus.inst_addr_i    = 32'h0040_0050;
    bus.wb_cp0_we_i    = 1'b1;
    bus.wb_cp0_waddr_i = 5'd13;
    bus.wb_cp0_data_i  = 32'hffff_fcff;
    settle();
    expect_exc("sw.mask", 32'h0, 32'h0, 32'h0);
    cyc();
    bus.inst_addr_i    = 32'h0040_0054;
    bus.wb_cp0_we_i    = 1'b1;
    bus.wb_cp0_waddr_i = 5'd13;
    bus.wb_cp0_data_i  = 32'h0000_0100;
    settle();
    expect_exc("sw.int", 32'h01, 32'h0, 32'h8000_0180);
    bus.cp0_status_i = 32'd0;
    cyc(); cyc(); cyc();

    // Fetch error outranks overflow
    bus.inst_addr_i = 32'h0040_0003;
    bus.exc_flags_i = 7'h11;
    settle();
    expect_exc("fetch", 32'h0f, 32'h0040_0003, 32'h8000_0180);
    cyc(); cyc(); cyc();

    // Load/store error blocked by stall, then issued
    bus.inst_addr_i = 32'h0040_0060;
    bus.exc_flags_i = 7'h40;
    bus.mem_addr_i  = 32'h1001;
    bus.stall_i     = 1'b1;
    settle();
    expect_exc("ls.stall", 32'h0, 32'h0, 32'h0);
    check("ls.stall.busy", {31'd0, bus.busy_o}, 32'd0);
    cyc();
    bus.inst_addr_i = 32'h0040_0060;
    bus.exc_flags_i = 7'h40;
    bus.mem_addr_i  = 32'h1001;
    settle();
    expect_exc("ls", 32'h0f, 32'h1001, 32'h8000_0180);
    cyc(); cyc(); cyc();

    // Overflow in both drain cycles ignored; taken at earliest slot
    bus.inst_addr_i = 32'h0040_0070;
    bus.exc_flags_i = 7'h04;
    settle();
    expect_exc("drain.sys", 32'h08, 32'h0, 32'h8000_0180);
    cyc();
    bus.inst_addr_i = 32'h0040_0074;
    bus.exc_flags_i = 7'h10;
    settle();
    expect_exc("drain.ov1", 32'h0, 32'h0, 32'h0);
    cyc();
    bus.inst_addr_i = 32'h0040_0078;
    bus.exc_flags_i = 7'h10;
    settle();
    expect_exc("drain.ov2", 32'h0, 32'h0, 32'h0);
    cyc();
    bus.inst_addr_i = 32'h0040_007c;
    bus.exc_flags_i = 7'h10;
    settle();
    expect_exc("ov", 32'h0c, 32'h0, 32'h8000_0180);

    // Reset mid-drain with an interrupt arriving: back to idle, interrupt lost
    cyc();
    bus.cp0_status_i = 32'h0000_0401;
    bus.int_i        = 6'h01;
    rst              = 1'b1;
    settle();
    check("rstd.busy_before", {31'd0, bus.busy_o}, 32'd1);
    cyc();
    rst = 1'b0;
    settle();
    check("rstd.busy_after", {31'd0, bus.busy_o}, 32'd0);
    cyc();
    bus.inst_addr_i = 32'h0040_0080;
    settle();
    expect_exc("rstd.int_lost", 32'h0, 32'h0, 32'h0);

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
